// File: rtl/conv_pkg.sv
// Shared constants and FSM state encoding for the binary 3x3 convolution job scheduler.
package conv_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam logic [15:0] END_MARK = 16'h00FF;
  localparam int MAX_DIM = 16;

  typedef enum logic [3:0] {
    IDLE,
    W_REQ,
    W_CAP,
    H_ROWS,
    H_COLS,
    CHECK,
    ISSUE,
    RUN,
    DONE
  } sched_state_e;

endpackage

// File: rtl/sram_read_mux.sv
// Input-SRAM read port arbitration: the engine owns the port while granted, the scheduler otherwise.
module sram_read_mux
  import conv_pkg::*;
#(
  parameter int ADDR_W = conv_pkg::ADDR_W
) (
  input  logic              grant,
  input  logic [ADDR_W-1:0] sched_addr,
  input  logic [ADDR_W-1:0] eng_addr,
  output logic [ADDR_W-1:0] read_addr
);

  assign read_addr = grant ? eng_addr : sched_addr;

endmodule

// File: rtl/conv_job_scheduler.sv
// Run sequencer: loads the kernel once, then walks input matrix headers and issues one engine job per legal matrix.
module conv_job_scheduler #(
  parameter int                 ADDR_W         = conv_pkg::ADDR_W,
  parameter int                 DATA_W         = conv_pkg::DATA_W,
  parameter logic [DATA_W-1:0]  END_MARK       = conv_pkg::END_MARK,
  parameter logic [ADDR_W-1:0]  IN_BASE        = '0,
  parameter logic [ADDR_W-1:0]  OUT_BASE       = '0,
  parameter logic [ADDR_W-1:0]  WMEM_DATA_ADDR = ADDR_W'(1),
  parameter int                 MAX_DIM        = conv_pkg::MAX_DIM
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              dut_run,
  output logic              dut_busy,
  output logic [ADDR_W-1:0] dut_wmem_read_address,
  input  logic [DATA_W-1:0] wmem_dut_read_data,
  output logic [ADDR_W-1:0] dut_sram_read_address,
  input  logic [DATA_W-1:0] sram_dut_read_data,
  input  logic [ADDR_W-1:0] eng_read_address,
  output logic [8:0]        weights_data,
  output logic              load_weights,
  output logic              job_valid,
  input  logic              job_ready,
  output logic [ADDR_W-1:0] job_in_base,
  output logic [4:0]        job_nrows,
  output logic [4:0]        job_ncols,
  output logic [ADDR_W-1:0] job_out_base,
  input  logic              job_done,
  output logic [7:0]        jobs_issued
);

  import conv_pkg::*;

  sched_state_e      state;
  logic [ADDR_W-1:0] in_ptr;
  logic [ADDR_W-1:0] out_ptr;
  logic [ADDR_W-1:0] sched_addr;
  logic [DATA_W-1:0] hdr_rows;
  logic [ADDR_W:0]   in_next;
  logic              unused_wmem_bits;

  function automatic logic dim_ok(input logic [DATA_W-1:0] d);
    return (d >= DATA_W'(3)) && (d <= DATA_W'(MAX_DIM));
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Next header address; the extra MSB flags a wrap past the top of the SRAM.
  assign in_next = {1'b0, in_ptr} + (ADDR_W+1)'(hdr_rows[4:0]) + (ADDR_W+1)'(2);
  assign unused_wmem_bits = ^wmem_dut_read_data[DATA_W-1:9];

  sram_read_mux #(.ADDR_W(ADDR_W)) u_mux (
    .grant      (state == RUN),
    .sched_addr (sched_addr),
    .eng_addr   (eng_read_address),
    .read_addr  (dut_sram_read_address)
  );

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state                 <= IDLE;
      dut_busy              <= 1'b0;
      dut_wmem_read_address <= '0;
      sched_addr            <= '0;
      weights_data          <= '0;
      load_weights          <= 1'b0;
      job_valid             <= 1'b0;
      job_in_base           <= '0;
      job_nrows             <= '0;
      job_ncols             <= '0;
      job_out_base          <= '0;
      jobs_issued           <= '0;
      in_ptr                <= IN_BASE;
      out_ptr               <= OUT_BASE;
      hdr_rows              <= '0;
    end else begin
      load_weights <= 1'b0;
      case (state)
        IDLE: begin
          if (dut_run) begin
            state                 <= W_REQ;
            dut_busy              <= 1'b1;
            in_ptr                <= IN_BASE;
            out_ptr               <= OUT_BASE;
            jobs_issued           <= '0;
            dut_wmem_read_address <= WMEM_DATA_ADDR;
          end
        end
        W_REQ: state <= W_CAP;
        W_CAP: begin
          weights_data <= wmem_dut_read_data[8:0];
          load_weights <= 1'b1;
          sched_addr   <= in_ptr;
          state        <= H_ROWS;
        end
        // Address is presented one state ahead so data lands in the sampling state.
        H_ROWS: begin
          sched_addr <= in_ptr + ADDR_W'(1);
          state      <= H_COLS;
        end
        H_COLS: begin
          hdr_rows <= sram_dut_read_data;
          state    <= (sram_dut_read_data == END_MARK) ? DONE : CHECK;
        end
        CHECK: begin
          if (dim_ok(hdr_rows) && dim_ok(sram_dut_read_data)) begin
            job_valid    <= 1'b1;
            job_in_base  <= in_ptr + ADDR_W'(2);
            job_nrows    <= hdr_rows[4:0];
            job_ncols    <= sram_dut_read_data[4:0];
            job_out_base <= out_ptr;
            state        <= ISSUE;
          end else if (in_next[ADDR_W]) begin
            state <= DONE;
          end else begin
            in_ptr     <= in_next[ADDR_W-1:0];
            sched_addr <= in_next[ADDR_W-1:0];
            state      <= H_ROWS;
          end
        end
        ISSUE: begin
          if (job_ready) begin
            job_valid   <= 1'b0;
            jobs_issued <= sat_inc8(jobs_issued);
            state       <= RUN;
          end
        end
        RUN: begin
          if (job_done) begin
            out_ptr <= out_ptr + ADDR_W'(job_nrows) - ADDR_W'(2);
            if (in_next[ADDR_W]) begin
              state <= DONE;
            end else begin
              in_ptr     <= in_next[ADDR_W-1:0];
              sched_addr <= in_next[ADDR_W-1:0];
              state      <= H_ROWS;
            end
          end
        end
        DONE: begin
          dut_busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
